// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   UART_DATA_BITS      = 8;
  localparam int   UART_BYTES_PER_WORD = 4;
  localparam logic UART_IDLE_LEVEL     = 1'b1;

  function automatic logic even_parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_word_tx.sv
// UART transmitter sending 32-bit words as four LSB-first 8N1 frames.
// Define UART_WORD_TX_PARITY_EN to insert an even-parity bit after each byte.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      word_data,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             tx,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  uart_state_e      state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       byte_q, byte_d;
  logic [31:0]      shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [7:0]       cur_byte;
  logic             tick;
  logic             baud_clr;

  // Restart the bit timer on every state change so each bit gets a full period.
  assign baud_clr = (state_q == IDLE) || (state_d != state_q);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (word_valid && ready_q) begin
          shift_d = word_data;
          bit_d   = '0;
          byte_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_WORD_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (byte_q == 2'(UART_BYTES_PER_WORD - 1)) begin
            sent_d  = sent_q + CNT_W'(1);
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            shift_d = shift_q >> UART_DATA_BITS;
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so tx comes straight from a flop.
  always_comb begin
    cur_byte = shift_d[7:0];
    ready_d  = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
    case (state_d)
      START:   tx_d = ~UART_IDLE_LEVEL;
      DATA:    tx_d = cur_byte[bit_d];
`ifdef UART_WORD_TX_PARITY_EN
      PARITY:  tx_d = even_parity8(cur_byte);
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end

  assign word_ready = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign words_sent = sent_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: line waveform and byte decode against a frame model.
module tb_uart_word_tx;

  localparam int N  = 4;
  localparam int CW = 3;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int WT = 4 * FB * N;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] words_sent;

  uart_word_tx #(
    .CLKS_PER_BIT(N),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .tx        (tx),
    .busy      (busy),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int vectors   = 0;
  int errors    = 0;
  int exp_count = 0;
  int last_wait = 0;

  typedef struct {
    logic [31:0] word;
    bit          hold;
    bit          corrupt;
    logic [31:0] exp_bytes;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Expected line level c cycles after the handshake, from the frame layout.
  function automatic logic exp_bit(input logic [31:0] w, input int c);
    int         frame = c / (FB * N);
    int         pos   = (c % (FB * N)) / N;
    logic [7:0] b     = 8'(w >> (8 * frame));
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
`ifdef UART_WORD_TX_PARITY_EN
    if (pos == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic send_word(input logic [31:0] w, input bit hold, input bit corrupt,
                           input logic [31:0] exp_bytes);
    int          waited;
    int          bad;
    int          frame;
    int          pos;
    logic [31:0] got;
    word_data  = w;
    word_valid = 1'b1;
    waited     = 0;
    while (word_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    last_wait = waited;
    if (word_ready !== 1'b1) check("ready_timeout", {31'd0, word_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) word_valid = 1'b0;
    bad = 0;
    got = '0;
    for (int c = 0; c < WT; c++) begin
      if (c > 0) @(negedge clk);
      if (corrupt && c == 50) word_data = 32'hDEADBEEF;
      if (tx !== exp_bit(w, c) || busy !== 1'b1 || word_ready !== 1'b0) bad++;
      frame = c / (FB * N);
      pos   = (c % (FB * N)) / N;
      if ((c % N) == N / 2 && pos >= 1 && pos <= 8) got[8*frame + pos - 1] = tx;
    end
    check("wave_bad_cycles", bad, 0);
    check("decoded_bytes", got, exp_bytes);
    @(negedge clk);
    exp_count = (exp_count + 1) % (1 << CW);
    check("idle_busy_ready_tx", {29'd0, busy, word_ready, tx}, 32'b011);
    check("words_sent", {29'd0, words_sent}, exp_count);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[6];
    bit          prev_hold;
    logic [31:0] w;
    bit          h;

    tbl[0] = '{32'h00708093, 1'b0, 1'b0, 32'h00708093};
    tbl[1] = '{32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF};
    tbl[2] = '{32'h00000000, 1'b0, 1'b0, 32'h00000000};
    tbl[3] = '{32'h12345678, 1'b1, 1'b1, 32'h12345678};
    tbl[4] = '{32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[5] = '{32'hA5C30F1E, 1'b0, 1'b0, 32'hA5C30F1E};

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", {28'd0, tx, busy, word_ready, 1'b0}, 32'b1000);
      check("reset_count", {29'd0, words_sent}, 32'd0);
    end
    rst = 1'b1;
    #1;
    check("ready_before_edge", {31'd0, word_ready}, 32'd0);
    @(negedge clk);
    check("ready_after_release", {31'd0, word_ready}, 32'd1);

    prev_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].word, tbl[i].hold, tbl[i].corrupt, tbl[i].exp_bytes);
      if (prev_hold) check("stream_gap_wait", last_wait, 0);
      prev_hold = tbl[i].hold;
    end

    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      h = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_word(w, h, 1'b0, w);
      if (prev_hold) check("rand_stream_gap", last_wait, 0);
      prev_hold = h;
    end

    w          = $urandom;
    word_data  = w;
    word_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    word_valid = 1'b0;
    repeat (49) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    exp_count = 0;
    check("midreset_async", {29'd0, tx, busy, word_ready}, 32'b100);
    check("midreset_count", {29'd0, words_sent}, 32'd0);
    repeat (3) @(negedge clk);
    check("midreset_hold", {29'd0, tx, busy, word_ready}, 32'b100);
    rst = 1'b1;
    w = $urandom;
    send_word(w, 1'b0, 1'b0, w);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
